// File: rtl/multiply_booth_seq_if.sv
// Handshake and result bundle for multiply_booth_seq.
// The is_signed wire exists only when MULT_BOOTH_UNSIGNED_EN is defined.
interface multiply_booth_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] Ra;
  logic [WIDTH-1:0] Rb;
`ifdef MULT_BOOTH_UNSIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

`ifdef MULT_BOOTH_UNSIGNED_EN
  modport master (output start, Ra, Rb, is_signed, input busy, done, HI, LO);
  modport slave  (input start, Ra, Rb, is_signed, output busy, done, HI, LO);
`else
  modport master (output start, Ra, Rb, input busy, done, HI, LO);
  modport slave  (input start, Ra, Rb, output busy, done, HI, LO);
`endif
endinterface

// File: rtl/multiply_booth_seq.sv
// Sequential radix-4 Booth multiplier, one Booth digit retired per clock.
// Product goes to registered HI/LO with a one-cycle done pulse.
// Optional feature macro MULT_BOOTH_UNSIGNED_EN adds the is_signed input and
// an unsigned mode (operands zero-extended by 2 bits, WIDTH/2+1 digits).
module multiply_booth_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic                 clock,
  input logic                 clear_n,
  multiply_booth_seq_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
`ifdef MULT_BOOTH_UNSIGNED_EN
  // Multiplier register: 2 zero-extension bits, operand, implicit b[-1].
  localparam int unsigned BW    = WIDTH + 3;
  localparam int unsigned N_MAX = WIDTH / 2 + 1;
`else
  localparam int unsigned BW    = WIDTH + 1;
  localparam int unsigned N_MAX = WIDTH / 2;
`endif
  localparam int unsigned CW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
`ifdef MULT_BOOTH_UNSIGNED_EN
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);
`endif

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   m_q, m_d;
  logic [BW-1:0]   b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            done_q, done_d;
`ifdef MULT_BOOTH_UNSIGNED_EN
  logic            uns_q, uns_d;
`endif

  logic [CW-1:0]   last_cnt;
  logic            last_step;
  logic [PW-1:0]   m_x2;
  logic [PW-1:0]   term;
  logic [PW-1:0]   acc_sum;
  logic            accept;
  logic            m_ext_bit;

  // Final digit index depends on the mode captured at accept time.
  always_comb begin
`ifdef MULT_BOOTH_UNSIGNED_EN
    last_cnt = uns_q ? LAST_U : LAST_S;
`else
    last_cnt = LAST_S;
`endif
    last_step = (state_q == RUN) && (cnt_q == last_cnt);
    accept    = (state_q == IDLE) && bus.start;
  end

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, leave RUN after the last digit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from flops; no input reaches an output combinationally.
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.HI   = hi_q;
    bus.LO   = lo_q;
  end

  // Booth digit select on the low triple of the shifting multiplier register.
  always_comb begin
    m_x2 = {m_q[PW-2:0], 1'b0};
    unique case (b_q[2:0])
      3'b001, 3'b010: term = m_q;
      3'b011:         term = m_x2;
      3'b100:         term = ~m_x2 + PW'(1);
      3'b101, 3'b110: term = ~m_q + PW'(1);
      default:        term = '0;
    endcase
    acc_sum = acc_q + term;
  end

  // Datapath next values. The multiplicand shifts left and the multiplier
  // right by two each step, so digit i always sees M*4^i and triple i at bit 0.
  always_comb begin
    acc_d  = acc_q;
    m_d    = m_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
`ifdef MULT_BOOTH_UNSIGNED_EN
    uns_d     = uns_q;
    m_ext_bit = bus.Ra[WIDTH-1] & bus.is_signed;
`else
    m_ext_bit = bus.Ra[WIDTH-1];
`endif
    if (accept) begin
      acc_d = '0;
      cnt_d = '0;
      m_d   = {{WIDTH{m_ext_bit}}, bus.Ra};
`ifdef MULT_BOOTH_UNSIGNED_EN
      uns_d = ~bus.is_signed;
      b_d   = {2'b00, bus.Rb, 1'b0};
`else
      b_d   = {bus.Rb, 1'b0};
`endif
    end else if (state_q == RUN) begin
      acc_d = acc_sum;
      m_d   = m_q << 2;
      b_d   = b_q >> 2;
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        hi_d   = acc_sum[PW-1:WIDTH];
        lo_d   = acc_sum[WIDTH-1:0];
        done_d = 1'b1;
      end
    end
  end

  // Datapath registers; reset clears results so an aborted run leaves HI/LO at 0.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      acc_q  <= '0;
      m_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MULT_BOOTH_UNSIGNED_EN
      uns_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      m_q    <= m_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
`ifdef MULT_BOOTH_UNSIGNED_EN
      uns_q  <= uns_d;
`endif
    end
  end

endmodule
